alu_mul_ctrl: RTL

Multi-cycle controller that computes an unsigned DATA_WIDTH×DATA_WIDTH→2·DATA_WIDTH product by sequencing a shared `alu` instance through shift-add iterations.
- It sits beside the ALU in the datapath and drives the ALU operand and op ports while busy.
- It accepts operands via a valid/ready handshake and returns the 64-bit result via a valid/ready handshake.
- The ALU itself stays purely combinational; this block owns all sequencing state.

---
 rtl/alu_mul_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_mul_ctrl.sv
// Shift-add multiplier sequencer: drives a shared combinational ALU (ADD) for
// DATA_WIDTH iterations to form an unsigned 2*DATA_WIDTH-bit product.
module alu_mul_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic [DATA_WIDTH-1:0] out_lo,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_CarryOut
);

    localparam int              CNT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [2:0]      OP_ADD = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [DATA_WIDTH-1:0]   hi;
    logic [DATA_WIDTH-1:0]   lo;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_WIDTH-1:0] step;

    // One shift-add iteration: the ALU carry re-enters at the top of hi, so the
    // {hi, lo} pair shifts right by one with no information lost.
    function automatic logic [2*DATA_WIDTH-1:0] shift_step(
        input logic                  c,
        input logic [DATA_WIDTH-1:0] sum,
        input logic [DATA_WIDTH-1:0] lo_cur
    );
        return {c, sum[DATA_WIDTH-1:1], sum[0], lo_cur[DATA_WIDTH-1:1]};
    endfunction

    assign step = shift_step(alu_CarryOut, alu_Result, lo);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_A     = '0;
        alu_B     = '0;
        alu_ALUop = OP_ADD;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                alu_A = hi;
                alu_B = lo[0] ? mcand : '0;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= in_a;
                        hi    <= '0;
                        lo    <= in_b;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    hi  <= step[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo  <= step[DATA_WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_hi = hi;
    assign out_lo = lo;

endmodule
